// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported, variable-latency memory between the fetch port and the load/store port.
// One transaction at a time; alternates on contention and returns read data or a timeout error.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_err,

    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_err,

    output logic                m_req,
    output logic                m_we,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_be,
    input  logic                m_ready,
    input  logic [DATA_W-1:0]   m_rdata
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               prio_d;
    logic               prio_d_next;
    logic [CNT_W-1:0]   tmo_cnt;

    logic               busy;
    logic               grant_i;
    logic               grant_d;
    logic               done_ok;
    logic               timed_out;
    logic               finish;
    logic [DATA_W-1:0]  resp_data;

    // prio_d names the side that wins when both requesters contend in IDLE
    assign busy      = (state != IDLE);
    assign grant_i   = (state == IDLE) && i_req && (!d_req || !prio_d);
    assign grant_d   = (state == IDLE) && d_req && (!i_req || prio_d);
    assign done_ok   = busy && m_ready;
    assign timed_out = busy && !m_ready && (TIMEOUT != 0) &&
                       (tmo_cnt == CNT_W'(TIMEOUT - 1));
    assign finish    = done_ok || timed_out;
    assign resp_data = (done_ok && !m_we) ? m_rdata : '0;

    assign i_gnt = grant_i;
    assign d_gnt = grant_d;
    assign m_req = busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            prio_d <= 1'b1;
        end else begin
            state  <= state_next;
            prio_d <= prio_d_next;
        end
    end

    always_comb begin
        state_next  = state;
        prio_d_next = prio_d;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    state_next = BUSY_D;
                end else if (grant_i) begin
                    state_next = BUSY_I;
                end
            end
            BUSY_I: begin
                if (finish) begin
                    state_next  = IDLE;
                    prio_d_next = 1'b1;
                end
            end
            BUSY_D: begin
                if (finish) begin
                    state_next  = IDLE;
                    prio_d_next = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Fetches are always plain reads, so the write-side fields are zeroed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            m_be    <= '0;
        end else if (grant_d) begin
            m_we    <= d_we;
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
            m_be    <= d_be;
        end else if (grant_i) begin
            m_we    <= 1'b0;
            m_addr  <= i_addr;
            m_wdata <= '0;
            m_be    <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (grant_i || grant_d) begin
            tmo_cnt <= '0;
        end else if (busy && !m_ready && (TIMEOUT != 0)) begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_rvalid <= 1'b0;
            i_err    <= 1'b0;
            i_rdata  <= '0;
        end else begin
            i_rvalid <= finish && (state == BUSY_I);
            i_err    <= timed_out && (state == BUSY_I);
            if (finish && (state == BUSY_I)) begin
                i_rdata <= resp_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_rvalid <= 1'b0;
            d_err    <= 1'b0;
            d_rdata  <= '0;
        end else begin
            d_rvalid <= finish && (state == BUSY_D);
            d_err    <= timed_out && (state == BUSY_D);
            if (finish && (state == BUSY_D)) begin
                d_rdata <= resp_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by randomized traffic,
// checked against a transaction-level model of grant order, latency and response contents.
module tb_mem_port_arbiter;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        i_err;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_be;
    logic        m_ready;
    logic [31:0] m_rdata;

    int checks = 0;
    int errors = 0;

    // Transaction-level model state
    bit          prio_d_m;
    bit          i_pend;
    bit          d_pend;
    bit          resp_pending;
    bit          resp_side_d;
    bit          resp_err;
    logic [31:0] resp_data;
    logic [31:0] last_i_rdata;
    logic [31:0] last_d_rdata;

    mem_port_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_gnt    (i_gnt),
        .i_rvalid (i_rvalid),
        .i_rdata  (i_rdata),
        .i_err    (i_err),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_be     (d_be),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .d_err    (d_err),
        .m_req    (m_req),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_be     (m_be),
        .m_ready  (m_ready),
        .m_rdata  (m_rdata)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Checks the cycle in which a response (or none) is due, with the DUT back in IDLE
    task automatic checkResponse();
        checkOutput("m_req_idle", m_req, 1'b0);
        if (resp_pending) begin
            checkOutput("i_rvalid", i_rvalid, !resp_side_d);
            checkOutput("d_rvalid", d_rvalid, resp_side_d);
            if (resp_side_d) begin
                checkOutput("d_err", d_err, resp_err);
                checkOutput("d_rdata", d_rdata, resp_data);
                checkOutput("i_rdata_hold", i_rdata, last_i_rdata);
                last_d_rdata = resp_data;
            end else begin
                checkOutput("i_err", i_err, resp_err);
                checkOutput("i_rdata", i_rdata, resp_data);
                checkOutput("d_rdata_hold", d_rdata, last_d_rdata);
                last_i_rdata = resp_data;
            end
            resp_pending = 1'b0;
        end else begin
            checkOutput("i_rvalid_quiet", i_rvalid, 1'b0);
            checkOutput("d_rvalid_quiet", d_rvalid, 1'b0);
            checkOutput("i_rdata_hold", i_rdata, last_i_rdata);
            checkOutput("d_rdata_hold", d_rdata, last_d_rdata);
        end
    endtask

    // One arbitration round starting in an IDLE cycle; lat = wait cycles before m_ready
    task automatic applyStimulus(input bit want_i, input bit want_d, input logic [31:0] ia,
                                 input logic [31:0] da, input logic [31:0] dw, input bit dwe,
                                 input logic [3:0] dbe, input int lat, input logic [31:0] mrd);
        bit          side_d;
        int          n_busy;
        logic        exp_we;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_be;
        logic [31:0] rd;
        checkResponse();
        if (!want_i && i_pend) begin i_req = 1'b0; i_pend = 1'b0; end
        if (!want_d && d_pend) begin d_req = 1'b0; d_pend = 1'b0; end
        if (want_i && !i_pend) begin i_req = 1'b1; i_addr = ia; i_pend = 1'b1; end
        if (want_d && !d_pend) begin
            d_req = 1'b1; d_addr = da; d_wdata = dw; d_we = dwe; d_be = dbe; d_pend = 1'b1;
        end
        m_ready = 1'($urandom_range(0, 1));
        m_rdata = $urandom;
        #1;
        if (!i_pend && !d_pend) begin
            checkOutput("i_gnt_none", i_gnt, 1'b0);
            checkOutput("d_gnt_none", d_gnt, 1'b0);
            nextCycle();
            return;
        end
        side_d = d_pend && (!i_pend || prio_d_m);
        checkOutput("i_gnt", i_gnt, !side_d);
        checkOutput("d_gnt", d_gnt, side_d);
        exp_we    = side_d ? d_we    : 1'b0;
        exp_addr  = side_d ? d_addr  : i_addr;
        exp_wdata = side_d ? d_wdata : 32'h0;
        exp_be    = side_d ? d_be    : 4'h0;
        nextCycle();
        // The winner drops its request and its bus fields turn to garbage
        if (side_d) begin
            d_req = 1'b0; d_pend = 1'b0;
            d_addr = $urandom; d_wdata = $urandom; d_we = 1'($urandom); d_be = 4'($urandom);
        end else begin
            i_req = 1'b0; i_pend = 1'b0; i_addr = $urandom;
        end
        n_busy = (lat + 1 <= TMO) ? lat + 1 : TMO;
        rd = 32'h0;
        for (int k = 1; k <= n_busy; k++) begin
            m_ready = (k == lat + 1);
            m_rdata = (k == lat + 1) ? mrd : $urandom;
            if (k == lat + 1) rd = mrd;
            #1;
            checkOutput("m_req_busy", m_req, 1'b1);
            checkOutput("m_we", m_we, exp_we);
            checkOutput("m_addr", m_addr, exp_addr);
            checkOutput("m_wdata", m_wdata, exp_wdata);
            checkOutput("m_be", m_be, exp_be);
            checkOutput("i_gnt_busy", i_gnt, 1'b0);
            checkOutput("d_gnt_busy", d_gnt, 1'b0);
            nextCycle();
        end
        m_ready      = 1'b0;
        resp_pending = 1'b1;
        resp_side_d  = side_d;
        resp_err     = (lat + 1 > TMO);
        resp_data    = (!resp_err && !exp_we) ? rd : 32'h0;
        prio_d_m     = !side_d;
    endtask

    initial begin
        rst = 1'b1;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
        m_ready = 1'b0; m_rdata = '0;
        prio_d_m = 1'b1; i_pend = 1'b0; d_pend = 1'b0; resp_pending = 1'b0;
        last_i_rdata = '0; last_d_rdata = '0;
        #2;
        checkOutput("rst_i_gnt", i_gnt, 1'b0);
        checkOutput("rst_d_gnt", d_gnt, 1'b0);
        checkOutput("rst_m_req", m_req, 1'b0);
        checkOutput("rst_m_addr", m_addr, 32'h0);
        checkOutput("rst_m_we", m_we, 1'b0);
        checkOutput("rst_i_rdata", i_rdata, 32'h0);
        checkOutput("rst_d_rdata", d_rdata, 32'h0);
        checkOutput("rst_i_err", i_err, 1'b0);
        checkOutput("rst_d_err", d_err, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        nextCycle();

        $display("[TB] directed: load, contention, store, timeout");
        applyStimulus(0, 1, 32'h0, 32'h100, 32'h0, 0, 4'hF, 0, 32'hDEADBEEF);
        for (int n = 0; n < 4; n++)
            applyStimulus(1, 1, 32'h400 + 32'(n * 4), 32'h800 + 32'(n * 4), 32'h0, 0, 4'hF, n % 2, $urandom);
        applyStimulus(0, 1, 32'h0, 32'h20, 32'h12345678, 1, 4'hF, 3, 32'hCAFEF00D);
        applyStimulus(1, 0, 32'h40, 32'h0, 32'h0, 0, 4'h0, 50, 32'h11111111);
        applyStimulus(1, 1, 32'h44, 32'h60, 32'h0, 0, 4'h3, 3, 32'h22222222);
        applyStimulus(1, 0, 32'h48, 32'h0, 32'h0, 0, 4'h0, 3, 32'h33333333);
        applyStimulus(0, 1, 32'h0, 32'h64, 32'hA5A5A5A5, 1, 4'h0, 1, 32'h44444444);

        $display("[TB] directed: reset in BUSY_D");
        checkResponse();
        i_req = 1'b0; i_pend = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_be = 4'hF;
        #1;
        checkOutput("rst_mid_d_gnt", d_gnt, 1'b1);
        nextCycle();
        d_req = 1'b0;
        #1;
        checkOutput("rst_mid_m_req1", m_req, 1'b1);
        nextCycle();
        #1;
        checkOutput("rst_mid_m_req2", m_req, 1'b1);
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_m_req_drop", m_req, 1'b0);
        checkOutput("rst_mid_m_addr", m_addr, 32'h0);
        checkOutput("rst_mid_d_rvalid", d_rvalid, 1'b0);
        checkOutput("rst_mid_d_rdata", d_rdata, 32'h0);
        rst = 1'b0;
        prio_d_m = 1'b1; d_pend = 1'b0; resp_pending = 1'b0;
        last_i_rdata = '0; last_d_rdata = '0;
        nextCycle();
        applyStimulus(1, 1, 32'h300, 32'h304, 32'h0, 0, 4'hF, 0, 32'h55555555);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 80; n++)
            applyStimulus(1'($urandom), 1'($urandom), $urandom, $urandom, $urandom, 1'($urandom),
                          4'($urandom), $urandom_range(0, 6), $urandom);
        checkResponse();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
